// File: rtl/ranc_input_feeder.sv
// Host-to-grid input feeder: a first-word-fall-through packet FIFO plus a tick
// sequencer that fires a grid tick only after the FIFO and the grid have gone quiet.
module ranc_input_feeder #(
    parameter int DEPTH         = 256,
    parameter int PACKET_WIDTH  = 30,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [PACKET_WIDTH-1:0]   wr_data,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    count,
    input  logic                      tick_req,
    input  logic                      grid_idle,
    input  logic                      ren_in,
    output logic [PACKET_WIDTH-1:0]   packet_out,
    output logic                      empty_out,
    output logic                      tick,
    output logic                      busy,
    output logic                      overflow_error,
    output logic                      underflow_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, DRAIN, TICK} state_t;

    logic [PACKET_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count_q;
    logic                    push;
    logic                    pop;

    state_t                  state;
    state_t                  state_nxt;
    logic [SW-1:0]           settle_cnt;
    logic [SW-1:0]           settle_nxt;
    logic                    pending;
    logic                    pending_nxt;
    logic                    quiet;

    // Flags come from the registered count only, so the grid never sees a
    // combinational path from wr_en or ren_in.
    assign empty_out  = (count_q == '0);
    assign full       = (count_q == (AW+1)'(DEPTH));
    assign count      = count_q;
    assign packet_out = mem[rd_ptr];

    // A pop on a full FIFO frees the slot the push lands in.
    assign push = wr_en && (!full || ren_in);
    assign pop  = ren_in && !empty_out;

    // NOTE: packet storage has no reset; stale contents are unreachable once the
    // pointers and count are cleared, and skipping the reset keeps it RAM-friendly.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: every register in a clocked block uses <= so all updates see the
    // pre-edge values; mixing in = here creates order-dependent simulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count_q         <= '0;
            overflow_error  <= 1'b0;
            underflow_error <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (wr_en && full && !ren_in) overflow_error  <= 1'b1;
            if (ren_in && empty_out)      underflow_error <= 1'b1;
        end
    end

    // A cycle counts toward settling only if nothing is queued, the grid is idle
    // and no new packet is arriving.
    assign quiet = empty_out && grid_idle && !push;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            pending    <= 1'b0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
            pending    <= pending_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path through it leaves a value unassigned, which would infer a latch.
    always_comb begin
        state_nxt   = state;
        settle_nxt  = '0;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                if (tick_req || pending) begin
                    state_nxt   = DRAIN;
                    pending_nxt = 1'b0;
                end
            end
            DRAIN: begin
                if (tick_req) pending_nxt = 1'b1;
                if (settle_cnt == SETTLE_MAX) begin
                    state_nxt = TICK;
                end else if (quiet) begin
                    settle_nxt = settle_cnt + SW'(1);
                end
            end
            TICK: begin
                if (tick_req) pending_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // TICK always returns through IDLE, so the pulse can never repeat back-to-back.
    assign tick = (state == TICK);
    assign busy = (state != IDLE) || pending;

endmodule

// File: tb/tb_ranc_input_feeder.sv
// Scoreboard bench for ranc_input_feeder: stimulus queues expected packets and
// tick cycles, negedge monitors pop and compare whenever the DUT presents them.
module tb_ranc_input_feeder;

    localparam int DEPTH = 4;
    localparam int PW    = 30;
    localparam int SC    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [PW-1:0] wr_data;
    logic          full;
    logic [2:0]    count;
    logic          tick_req;
    logic          grid_idle;
    logic          ren_in;
    logic [PW-1:0] packet_out;
    logic          empty_out;
    logic          tick;
    logic          busy;
    logic          overflow_error;
    logic          underflow_error;

    ranc_input_feeder #(.DEPTH(DEPTH), .PACKET_WIDTH(PW), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .count(count), .tick_req(tick_req), .grid_idle(grid_idle), .ren_in(ren_in),
        .packet_out(packet_out), .empty_out(empty_out), .tick(tick), .busy(busy),
        .overflow_error(overflow_error), .underflow_error(underflow_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [PW-1:0] data_q[$];
    int            tick_q[$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic          tick_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_pkt(input logic [PW-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        data_q.push_back(d);
        step();
        wr_en   = 1'b0;
    endtask

    // Monitor: popped packets and tick pulses are checked against the queues.
    always @(negedge clk) begin
        if (!reset && ren_in && !empty_out) begin
            if (data_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pop: got 0x%0h with nothing expected (cycle %0d)", packet_out, cyc);
            end else begin
                check("pop_data", 32'(packet_out), 32'(data_q.pop_front()));
            end
        end
        if (tick) begin
            if (tick_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_tick: tick=1 with none expected (cycle %0d)", cyc);
            end else begin
                check("tick_cycle", 32'(cyc), 32'(tick_q.pop_front()));
            end
            if (tick_prev) begin
                n_checks++;
                n_errors++;
                $display("FAIL tick_back_to_back: tick=1 two cycles running (cycle %0d)", cyc);
            end
        end
        tick_prev = tick;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; tick_req = 1'b0;
        grid_idle = 1'b1; ren_in = 1'b0;
        step(2);
        check("rst_empty", 32'(empty_out), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow_error), 32'd0);
        check("rst_udf", 32'(underflow_error), 32'd0);
        reset = 1'b0;
        step();

        // In-order delivery of three packets.
        push_pkt(30'h0000001);
        push_pkt(30'h3FFFFFF);
        push_pkt(30'h1555555);
        check("three_count", 32'(count), 32'd3);
        ren_in = 1'b1;
        step(3);
        ren_in = 1'b0;
        check("three_empty", 32'(empty_out), 32'd1);
        check("three_count0", 32'(count), 32'd0);
        check("three_ovf", 32'(overflow_error), 32'd0);
        check("three_udf", 32'(underflow_error), 32'd0);

        // Fill, overflow, then push-with-pop while full.
        push_pkt(30'h0000A01);
        push_pkt(30'h0000B02);
        push_pkt(30'h0000C03);
        push_pkt(30'h0000D04);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd4);
        wr_en = 1'b1; wr_data = 30'h0000E05;
        step();
        wr_en = 1'b0;
        check("ovf_flag", 32'(overflow_error), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        wr_en = 1'b1; wr_data = 30'h0000F06; ren_in = 1'b1;
        data_q.push_back(30'h0000F06);
        step();
        wr_en = 1'b0; ren_in = 1'b0;
        check("fullpp_count", 32'(count), 32'd4);
        check("fullpp_head", 32'(packet_out), 32'h0000B02);
        ren_in = 1'b1;
        step(4);
        ren_in = 1'b0;
        check("fullpp_empty", 32'(empty_out), 32'd1);

        // Underflow leaves the FIFO alone; the next push is the next head.
        ren_in = 1'b1;
        step();
        ren_in = 1'b0;
        check("udf_flag", 32'(underflow_error), 32'd1);
        check("udf_count", 32'(count), 32'd0);
        check("udf_empty", 32'(empty_out), 32'd1);
        push_pkt(30'h2AAAAAA);
        check("udf_head", 32'(packet_out), 32'h2AAAAAA);
        ren_in = 1'b1;
        step();
        ren_in = 1'b0;
        check("ovf_sticky", 32'(overflow_error), 32'd1);

        // Minimum-latency tick.
        c = cyc;
        tick_q.push_back(c + SC + 2);
        tick_req = 1'b1;
        step();
        tick_req = 1'b0;
        step(SC);
        check("lat_busy_pre", 32'(busy), 32'd1);
        check("lat_tick_pre", 32'(tick), 32'd0);
        step();
        check("lat_tick", 32'(tick), 32'd1);
        step();
        check("lat_tick_off", 32'(tick), 32'd0);
        check("lat_busy_off", 32'(busy), 32'd0);

        // Tick held off by queued packets and grid activity, plus a merged second request.
        push_pkt(30'h0000111);
        push_pkt(30'h0000222);
        push_pkt(30'h0000333);
        c = cyc;
        tick_q.push_back(c + 11);
        tick_q.push_back(c + 18);
        tick_req = 1'b1; grid_idle = 1'b1; step();
        tick_req = 1'b1; ren_in = 1'b1; grid_idle = 1'b0; step();
        tick_req = 1'b0; grid_idle = 1'b1; step();
        grid_idle = 1'b0; step();
        ren_in = 1'b0; grid_idle = 1'b1; step();
        grid_idle = 1'b0; step();
        grid_idle = 1'b1; step(4);
        check("hold_no_tick", 32'(tick), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        step(10);
        check("hold_idle", 32'(busy), 32'd0);

        // Reset mid-DRAIN aborts the tick and discards the queue.
        push_pkt(30'h0000444);
        push_pkt(30'h0000555);
        tick_req = 1'b1; step();
        tick_req = 1'b0; step(2);
        reset = 1'b1;
        data_q.delete();
        step();
        reset = 1'b0;
        check("abort_empty", 32'(empty_out), 32'd1);
        check("abort_count", 32'(count), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ovf", 32'(overflow_error), 32'd0);
        check("abort_udf", 32'(underflow_error), 32'd0);
        step(12);
        check("abort_no_tick", 32'(tick), 32'd0);

        check("tick_q_drained", 32'(tick_q.size()), 32'd0);
        check("data_q_drained", 32'(data_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
